// File: rtl/sparse_match_scanner.sv
// rtl/sparse_match_scanner.sv - ANDs an IFM/filter bitmap pair and walks matches lowest-first with compressed offsets
module sparse_match_scanner #(
  parameter int MAP_W = 128,
  parameter int IDX_W = $clog2(MAP_W),
  parameter int CNT_W = $clog2(MAP_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [MAP_W-1:0] ifm_map_i,
  input  logic [MAP_W-1:0] fil_map_i,
  input  logic             clear_i,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] ifm_ofs_o,
  output logic [IDX_W-1:0] fil_ofs_o,
  output logic             last_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Captured bitmaps stay put for the whole scan so offsets can be derived
  // from them; r_rem holds the matches not yet handed out.
  logic [MAP_W-1:0] r_ifm;
  logic [MAP_W-1:0] r_fil;
  logic [MAP_W-1:0] r_rem;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_empty;

  logic [MAP_W-1:0] w_and;
  logic [CNT_W-1:0] w_and_cnt;
  logic [IDX_W-1:0] w_idx;
  logic [MAP_W-1:0] w_idx_onehot;
  logic [MAP_W-1:0] w_below_mask;
  logic [IDX_W-1:0] w_ifm_ofs;
  logic [IDX_W-1:0] w_fil_ofs;
  logic             w_last;
  logic             w_load_fire;
  logic             w_hs;

  assign w_and = ifm_map_i & fil_map_i;

  // Match count of the incoming pair, registered on load.
  always_comb begin
    w_and_cnt = '0;
    for (int k = 0; k < MAP_W; k++) begin
      w_and_cnt = w_and_cnt + CNT_W'(w_and[k]);
    end
  end

  // Priority encoder: position of the lowest remaining match (0 when none).
  always_comb begin
    w_idx = '0;
    for (int k = MAP_W - 1; k >= 0; k--) begin
      if (r_rem[k]) begin
        w_idx = IDX_W'(k);
      end
    end
  end

  assign w_idx_onehot = MAP_W'(1) << w_idx;
  assign w_below_mask = w_idx_onehot - MAP_W'(1);
  assign w_last       = (r_rem != '0) && ((r_rem & (r_rem - MAP_W'(1))) == '0);

  // Prefix popcounts below the current match give the compressed-buffer addresses.
  always_comb begin
    w_ifm_ofs = '0;
    w_fil_ofs = '0;
    for (int k = 0; k < MAP_W; k++) begin
      w_ifm_ofs = w_ifm_ofs + IDX_W'(r_ifm[k] & w_below_mask[k]);
      w_fil_ofs = w_fil_ofs + IDX_W'(r_fil[k] & w_below_mask[k]);
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake decode; clear wins over load and handshake.
  always_comb begin
    w_state_nxt  = r_state;
    load_ready_o = 1'b0;
    idx_valid_o  = 1'b0;
    w_load_fire  = 1'b0;
    w_hs         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready_o = 1'b1;
        w_load_fire  = load_valid_i & ~clear_i;
        if (w_load_fire && (w_and != '0)) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        idx_valid_o = 1'b1;
        w_hs        = idx_ready_i & ~clear_i;
        if (w_hs && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Datapath registers: capture on load, retire one match per handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ifm       <= '0;
      r_fil       <= '0;
      r_rem       <= '0;
      r_match_cnt <= '0;
      r_empty     <= 1'b0;
    end else begin
      r_empty <= w_load_fire && (w_and == '0);
      if (clear_i) begin
        r_rem <= '0;
      end else if (w_load_fire) begin
        r_ifm       <= ifm_map_i;
        r_fil       <= fil_map_i;
        r_rem       <= w_and;
        r_match_cnt <= w_and_cnt;
      end else if (w_hs) begin
        r_rem <= r_rem & ~w_idx_onehot;
      end
    end
  end

  assign idx_o       = w_idx;
  assign ifm_ofs_o   = w_ifm_ofs;
  assign fil_ofs_o   = w_fil_ofs;
  assign last_o      = w_last;
  assign empty_o     = r_empty;
  assign match_cnt_o = r_match_cnt;

endmodule
